// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the per-latch
// enable/flush pair.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        HALT_DRAIN,
        HALTED
    } pipe_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } pipe_ctl_t;

    // A flushed latch must not also load, so flush masks the enable.
    function automatic logic ctl_en(pipe_ctl_t c);
        return c.en & ~c.flush;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> sequencer bundle: hazard/cache status in, latch and PC controls out.
interface pipeline_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             dREN_MEM;
    logic             dWEN_MEM;
    logic             memtoReg_EX;
    logic [REG_W-1:0] Wsel_EX;
    logic [REG_W-1:0] rs_ID;
    logic [REG_W-1:0] rt_ID;
    logic             uses_rt_ID;
    logic             redirect_MEM;
    logic             halt_MEM;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             dmem_req;
    logic             halt;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX, Wsel_EX, rs_ID, rt_ID,
               uses_rt_ID, redirect_MEM, halt_MEM,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, memwb_flush, dmem_req, halt, stall_count
    );

    modport slave (
        input  ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX, Wsel_EX, rs_ID, rt_ID,
               uses_rt_ID, redirect_MEM, halt_MEM,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, memwb_flush, dmem_req, halt, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module load_use_detect #(
    parameter int REG_W      = 5,
    parameter bit LOADUSE_EN = 1'b1
) (
    input  logic             memtoReg_EX_i,
    input  logic [REG_W-1:0] Wsel_EX_i,
    input  logic [REG_W-1:0] rs_ID_i,
    input  logic [REG_W-1:0] rt_ID_i,
    input  logic             uses_rt_ID_i,
    output logic             stall_lu_o
);
    logic src_match;

    // $zero is never a real dependency, hence the nonzero test.
    assign src_match  = (Wsel_EX_i == rs_ID_i) | (uses_rt_ID_i & (Wsel_EX_i == rt_ID_i));
    assign stall_lu_o = LOADUSE_EN & memtoReg_EX_i & (Wsel_EX_i != '0) & src_match;
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: latch enables/flushes, PC enable, D-cache request gating,
// halt drain and a saturating stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int CNT_W      = 16,
    parameter bit LOADUSE_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    pipeline_ctrl_if.slave  bus
);
    pipe_state_t      state_q, state_d;
    logic             dmem_done_q, dmem_done_d;
    logic             halt_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             memop, dok, adv, stall_lu, pc_en_c;
    pipe_ctl_t        ifid_c, idex_c, exmem_c, memwb_c;

    assign memop = bus.dREN_MEM | bus.dWEN_MEM;
    assign dok   = ~memop | bus.dhit | dmem_done_q;
    assign adv   = bus.ihit & dok;

    load_use_detect #(
        .REG_W      (REG_W),
        .LOADUSE_EN (LOADUSE_EN)
    ) u_load_use (
        .memtoReg_EX_i (bus.memtoReg_EX),
        .Wsel_EX_i     (bus.Wsel_EX),
        .rs_ID_i       (bus.rs_ID),
        .rt_ID_i       (bus.rt_ID),
        .uses_rt_ID_i  (bus.uses_rt_ID),
        .stall_lu_o    (stall_lu)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        dmem_done_d = dmem_done_q;
        cnt_d       = cnt_q;
        pc_en_c     = 1'b0;
        ifid_c      = '0;
        idex_c      = '0;
        exmem_c     = '0;
        memwb_c     = '0;

        // Remember a dhit that arrives while an I-miss holds the pipe.
        if (adv)                    dmem_done_d = 1'b0;
        else if (memop && bus.dhit) dmem_done_d = 1'b1;

        unique case (state_q)
            RUN: begin
                if (!adv) begin
                    memwb_c.flush = 1'b1;
                end else if (bus.halt_MEM) begin
                    memwb_c.en    = 1'b1;
                    ifid_c.flush  = 1'b1;
                    idex_c.flush  = 1'b1;
                    exmem_c.flush = 1'b1;
                    state_d       = HALT_DRAIN;
                end else if (bus.redirect_MEM) begin
                    ifid_c        = '{en: 1'b1, flush: 1'b1};
                    idex_c        = '{en: 1'b1, flush: 1'b1};
                    exmem_c       = '{en: 1'b1, flush: 1'b1};
                    memwb_c.en    = 1'b1;
                    pc_en_c       = 1'b1;
                end else if (stall_lu) begin
                    idex_c.flush  = 1'b1;
                    exmem_c.en    = 1'b1;
                    memwb_c.en    = 1'b1;
                end else begin
                    ifid_c.en     = 1'b1;
                    idex_c.en     = 1'b1;
                    exmem_c.en    = 1'b1;
                    memwb_c.en    = 1'b1;
                    pc_en_c       = 1'b1;
                end
            end
            HALT_DRAIN: state_d = HALTED;
            HALTED:     state_d = HALTED;
            default:    state_d = RUN;
        endcase

        if (state_q == RUN && !pc_en_c && cnt_q != '1) cnt_d = cnt_q + 1'b1;

        if (RST) begin
            pc_en_c = 1'b0;
            ifid_c  = '{en: 1'b0, flush: 1'b1};
            idex_c  = '{en: 1'b0, flush: 1'b1};
            exmem_c = '{en: 1'b0, flush: 1'b1};
            memwb_c = '{en: 1'b0, flush: 1'b1};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (RST) begin
            state_q     <= RUN;
            dmem_done_q <= 1'b0;
            halt_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            dmem_done_q <= dmem_done_d;
            halt_q      <= (state_d == HALTED);
            cnt_q       <= cnt_d;
        end
    end

    assign bus.pc_en       = pc_en_c;
    assign bus.ifid_en     = ctl_en(ifid_c);
    assign bus.idex_en     = ctl_en(idex_c);
    assign bus.exmem_en    = ctl_en(exmem_c);
    assign bus.memwb_en    = ctl_en(memwb_c);
    assign bus.ifid_flush  = ifid_c.flush;
    assign bus.idex_flush  = idex_c.flush;
    assign bus.exmem_flush = exmem_c.flush;
    assign bus.memwb_flush = memwb_c.flush;
    assign bus.dmem_req    = memop & ~dmem_done_q;
    assign bus.halt        = halt_q;
    assign bus.stall_count = cnt_q;
endmodule
